ysyx_24100006_axi_sram: RTL and testbench

YSYX_24100006_AXI_SRAM -- requirements
Module: ysyx_24100006_axi_sram

---
 rtl/ysyx_24100006_axi_pkg.sv | 35 +++
 rtl/ysyx_24100006_sram_mem.sv | 42 ++++
 rtl/ysyx_24100006_axi_sram.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_sram.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_axi_pkg
// Shared definitions for the AXI SRAM slave: response codes, read/write FSM
// state encodings and the address-window helper used by both paths.
// ---------------------------------------------------------------------------
package ysyx_24100006_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_BEAT = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // True when addr lies in [base, base + span). Done in 33 bits so that a
    // window ending exactly at 4 GiB does not overflow.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
        logic [32:0] a;
        logic [32:0] b;
        a = {1'b0, addr};
        b = {1'b0, base};
        return (a >= b) && ((a - b) < span);
    endfunction

endpackage

// File: rtl/ysyx_24100006_sram_mem.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_sram_mem
// Word-organised storage: one combinational read port and one synchronous
// write port with per-byte enables. Contents are never reset.
//   clk      : write clock
//   rd_idx   : word index for the read port
//   rd_data  : word at rd_idx (combinational)
//   wr_en    : write strobe for this cycle
//   wr_idx   : word index for the write port
//   wr_be    : byte-lane enables
//   wr_data  : write data
// ---------------------------------------------------------------------------
module ysyx_24100006_sram_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = 12
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);

    // One byte-wide array per lane keeps every array single-writer.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
            end

            assign rd_data[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

endmodule

// File: rtl/ysyx_24100006_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_axi_sram
// AXI4 slave in front of a word SRAM. Read and write channels run as
// independent FSMs. Reads return full aligned words after a fixed latency;
// writes honour byte strobes. Out-of-window beats get SLVERR.
//   clk, reset          : clock and asynchronous active-high reset
//   aw*                 : write address channel (INCR bursts, awsize ignored)
//   w*                  : write data channel
//   b*                  : write response channel (one response per burst)
//   ar*                 : read address channel (arsize ignored)
//   r*                  : read data channel (response per beat)
// ---------------------------------------------------------------------------
module ysyx_24100006_axi_sram
    import ysyx_24100006_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    // write address
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    // write data
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    // write response
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    // read address
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    // read data
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_INIT = 4'(RD_LATENCY - 1);

    // Transfer sizes are irrelevant: reads return whole words, writes use strobes.
    logic unused_size;
    assign unused_size = ^{awsize, arsize};

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]      rd_load_addr;
    logic             rd_load_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      mem_rd_data;

    logic [31:0]      w_addr_q, w_addr_d;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;
    logic             mem_wr_en;

    assign rd_load_ok = addr_in_range(rd_load_addr, BASE_ADDR, SPAN);
    assign rd_idx     = IDX_W'((rd_load_addr - BASE_ADDR) >> 2);
    assign wr_ok      = addr_in_range(w_addr_q, BASE_ADDR, SPAN);
    assign wr_idx     = IDX_W'((w_addr_q - BASE_ADDR) >> 2);

    ysyx_24100006_sram_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rd_idx  (rd_idx),
        .rd_data (mem_rd_data),
        .wr_en   (mem_wr_en),
        .wr_idx  (wr_idx),
        .wr_be   (wstrb),
        .wr_data (wdata)
    );

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    // Beat data is captured into registers at the edge the beat is issued.
    // This holds it stable under backpressure, and because the memory reads
    // combinationally, a same-edge write to the same word is not yet visible.
    always_comb begin
        r_state_d    = r_state_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_beat_d     = r_beat_q;
        r_cnt_d      = r_cnt_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        rlast_d      = rlast_q;
        rd_load_addr = r_addr_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_beat_d  = 8'd0;
                    r_cnt_d   = LAT_INIT;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d = R_BEAT;
                    rdata_d   = rd_load_ok ? mem_rd_data : 32'd0;
                    rresp_d   = rd_load_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (r_len_q == 8'd0);
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_BEAT: begin
                // Look ahead to the next beat so it can follow back-to-back.
                rd_load_addr = r_addr_q + 32'd4;
                if (rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rdata_d   = 32'd0;
                        rresp_d   = RESP_OKAY;
                        rlast_d   = 1'b0;
                    end else begin
                        r_addr_d = r_addr_q + 32'd4;
                        r_beat_d = r_beat_q + 8'd1;
                        rdata_d  = rd_load_ok ? mem_rd_data : 32'd0;
                        rresp_d  = rd_load_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_beat_q  <= 8'd0;
            r_cnt_q   <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_BEAT);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_e   w_state_q, w_state_d;
    logic [7:0] w_len_q, w_len_d;
    logic [7:0] w_beat_q, w_beat_d;
    logic       w_err_q, w_err_d;
    logic [1:0] bresp_q, bresp_d;
    logic       w_beat_last;
    logic       w_err_now;

    always_comb begin
        w_state_d   = w_state_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_beat_d    = w_beat_q;
        w_err_d     = w_err_q;
        bresp_d     = bresp_q;
        mem_wr_en   = 1'b0;
        w_beat_last = (w_beat_q == w_len_q);
        w_err_now   = w_err_q;

        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_wr_en = wr_ok;
                    // Error is sticky: any out-of-window beat or any wlast
                    // that disagrees with awlen taints the whole burst.
                    w_err_now = w_err_q | ~wr_ok | (wlast != w_beat_last);
                    w_err_d   = w_err_now;
                    w_addr_d  = w_addr_q + 32'd4;
                    w_beat_d  = w_beat_q + 8'd1;
                    if (w_beat_last) begin
                        w_state_d = W_RESP;
                        bresp_d   = w_err_now ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bresp_d   = RESP_OKAY;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_beat_q  <= 8'd0;
            w_err_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_24100006_axi_sram.sv
module tb_ysyx_24100006_axi_sram;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_data_a [4];
    logic [1:0]  rd_resp_a [4];
    logic        rd_last_a [4];
    int          rd_lat;
    logic [1:0]  wr_resp;

    ysyx_24100006_axi_sram dut (
        .clk     (clk),
        .reset   (reset),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Single or burst write; beat i carries data0+i. bad_beat flips wlast on
    // that beat (-1 for a well-formed burst). Response lands in wr_resp.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] data0, input logic [3:0] strb,
                            input int bad_beat);
        int n;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = len; awsize = 3'd2;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = data0 + 32'(i);
            wstrb  = strb;
            wlast  = (i == int'(len)) != (i == bad_beat);
            n = 0;
            while (!wready && n < 20) begin @(negedge clk); n++; end
            chk("w_timeout", 32'(n < 20), 32'd1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_after_last_w", 32'(bvalid), 32'd1);
        wr_resp = bresp;
        bready  = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_dropped", 32'(bvalid), 32'd0);
        $display("WRITE addr=0x%08h len=%0d data0=0x%08h strb=%b bresp=%0d", addr, len, data0, strb, wr_resp);
    endtask

    // Read burst; with toggle set, rready follows 1,0,1,0,... and each stall
    // cycle checks that the presented beat is held.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
        int n;
        int beat;
        int ph;
        logic [31:0] snap;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arlen = len; arsize = 3'd2;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin @(negedge clk); n++; end
        rd_lat = n;
        chk("r_timeout", 32'(n < 40), 32'd1);
        beat = 0;
        ph   = 0;
        while (beat <= int'(len)) begin
            chk("rvalid_in_burst", 32'(rvalid), 32'd1);
            if (toggle && ph[0]) begin
                rready = 1'b0;
                snap   = rdata;
                @(negedge clk);
                chk("r_hold_stall", rdata, snap);
            end else begin
                rready = 1'b1;
                rd_data_a[beat] = rdata;
                rd_resp_a[beat] = rresp;
                rd_last_a[beat] = rlast;
                @(negedge clk);
                rready = 1'b0;
                beat++;
            end
            ph++;
        end
        chk("r_idle_after_burst", 32'(rvalid), 32'd0);
        chk("arready_after_burst", 32'(arready), 32'd1);
        $display("READ addr=0x%08h len=%0d lat=%0d beat0=0x%08h resp0=%0d", addr, len, rd_lat, rd_data_a[0], rd_resp_a[0]);
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 0; rready = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        $display("RESET checked");
        reset = 1'b0;

        // Single read with latency check
        do_write(32'h8000_0010, 8'd0, 32'hDEAD_BEEF, 4'hF, -1);
        chk("single_bresp", 32'(wr_resp), 32'd0);
        do_read(32'h8000_0010, 8'd0, 1'b0);
        chk("single_latency", 32'(rd_lat), 32'd2);
        chk("single_rdata", rd_data_a[0], 32'hDEAD_BEEF);
        chk("single_rlast", 32'(rd_last_a[0]), 32'd1);
        chk("single_rresp", 32'(rd_resp_a[0]), 32'd0);

        // Strobed write
        do_write(32'h8000_0000, 8'd0, 32'h1122_3344, 4'hF, -1);
        do_write(32'h8000_0000, 8'd0, 32'hAABB_CCDD, 4'b0101, -1);
        chk("strb_bresp", 32'(wr_resp), 32'd0);
        do_read(32'h8000_0000, 8'd0, 1'b0);
        chk("strb_rdata", rd_data_a[0], 32'h11BB_33DD);

        // Burst write then burst read with backpressure
        do_write(32'h8000_0020, 8'd3, 32'hA000_0000, 4'hF, -1);
        chk("burst_bresp", 32'(wr_resp), 32'd0);
        do_read(32'h8000_0020, 8'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_rdata%0d", i), rd_data_a[i], 32'hA000_0000 + 32'(i));
            chk($sformatf("burst_rlast%0d", i), 32'(rd_last_a[i]), 32'(i == 3));
            chk($sformatf("burst_rresp%0d", i), 32'(rd_resp_a[i]), 32'd0);
        end

        // Top-of-memory boundary read
        do_write(32'h8000_3FFC, 8'd0, 32'h5A5A_5A5A, 4'hF, -1);
        do_read(32'h8000_3FFC, 8'd1, 1'b0);
        chk("edge_b0_rdata", rd_data_a[0], 32'h5A5A_5A5A);
        chk("edge_b0_rresp", 32'(rd_resp_a[0]), 32'd0);
        chk("edge_b0_rlast", 32'(rd_last_a[0]), 32'd0);
        chk("edge_b1_rdata", rd_data_a[1], 32'd0);
        chk("edge_b1_rresp", 32'(rd_resp_a[1]), 32'd2);
        chk("edge_b1_rlast", 32'(rd_last_a[1]), 32'd1);

        // Out-of-range writes: error, and no aliasing into real words
        do_write(32'h8000_4000, 8'd0, 32'h1234_5678, 4'hF, -1);
        chk("oor_hi_bresp", 32'(wr_resp), 32'd2);
        do_write(32'h7FFF_FFFC, 8'd0, 32'h8765_4321, 4'hF, -1);
        chk("oor_lo_bresp", 32'(wr_resp), 32'd2);
        do_read(32'h8000_0000, 8'd0, 1'b0);
        chk("oor_word0_kept", rd_data_a[0], 32'h11BB_33DD);
        do_read(32'h8000_3FFC, 8'd0, 1'b0);
        chk("oor_top_kept", rd_data_a[0], 32'h5A5A_5A5A);

        // wlast disagreeing with awlen
        do_write(32'h8000_0100, 8'd1, 32'h0000_0100, 4'hF, 0);
        chk("wlast_early_bresp", 32'(wr_resp), 32'd2);
        do_write(32'h8000_0100, 8'd1, 32'h0000_0200, 4'hF, 1);
        chk("wlast_missing_bresp", 32'(wr_resp), 32'd2);
        do_write(32'h8000_0100, 8'd1, 32'h0000_0300, 4'hF, -1);
        chk("wlast_good_bresp", 32'(wr_resp), 32'd0);

        // Same-word read capture and write in one cycle
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h8000_0010; awlen = 8'd0;
        @(negedge clk);
        awvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h8000_0010; arlen = 8'd0;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'hFFFF_0000; wstrb = 4'hF; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        chk("coll_rvalid", 32'(rvalid), 32'd1);
        chk("coll_old_data", rdata, 32'hDEAD_BEEF);
        chk("coll_bvalid", 32'(bvalid), 32'd1);
        chk("coll_bresp", 32'(bresp), 32'd0);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        chk("coll_rvalid_done", 32'(rvalid), 32'd0);
        chk("coll_bvalid_done", 32'(bvalid), 32'd0);
        $display("COLLISION read got 0x%08h", rd_data_a[0]);
        do_read(32'h8000_0010, 8'd0, 1'b0);
        chk("coll_new_data", rd_data_a[0], 32'hFFFF_0000);

        // Asynchronous reset mid-transfer
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h8000_0040; awlen = 8'd0;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        arvalid = 1'b1; araddr = 32'h8000_0020; arlen = 8'd3;
        @(negedge clk);
        arvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rvalid", 32'(rvalid), 32'd0);
        chk("async_bvalid", 32'(bvalid), 32'd0);
        chk("async_arready", 32'(arready), 32'd1);
        chk("async_awready", 32'(awready), 32'd1);
        chk("async_wready", 32'(wready), 32'd0);
        chk("async_rdata", rdata, 32'd0);
        $display("ASYNC_RESET rvalid=%0d bvalid=%0d arready=%0d awready=%0d", rvalid, bvalid, arready, awready);
        @(negedge clk);
        reset = 1'b0;
        do_read(32'h8000_0040, 8'd0, 1'b0);
        chk("post_rst_mem_kept", rd_data_a[0], 32'h0BAD_F00D);
        do_read(32'h8000_0010, 8'd0, 1'b0);
        chk("post_rst_mem_kept2", rd_data_a[0], 32'hFFFF_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
